// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and instruction fields shared by the sequencer
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SFL  = 4'h2,
        OP_SFR  = 4'h3,
        OP_INC  = 4'h4,
        OP_DEC  = 4'h5,
        OP_BNE  = 4'h6,
        OP_BEQ  = 4'h7,
        OP_BLT  = 4'h8,
        OP_LHB  = 4'h9,
        OP_JMP  = 4'hA,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    // op kept as raw bits so illegal codes 1011-1110 survive the latch
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
    } inst_t;

endpackage

// File: rtl/alu_seq_rf.sv
// alu_seq_rf: 4x8 register file, one write port, two read ports, one debug read port
module alu_seq_rf (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [7:0] wd,
    input  logic [1:0] ra1,
    input  logic [1:0] ra2,
    input  logic [1:0] dbg_sel,
    output logic [7:0] rd1,
    output logic [7:0] rd2,
    output logic [7:0] dbg_rd
);

    logic [7:0] rf [4];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rf <= '{default: '0};
        else if (we) rf[wa] <= wd;
    end

    assign rd1    = rf[ra1];
    assign rd2    = rf[ra2];
    assign dbg_rd = rf[dbg_sel];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle fetch/decode/execute sequencer driving an external 8-bit ALU
// ALU_SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt instead of executing as NOP
module alu_seq import alu_seq_pkg::*; #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [15:0] imem_rdata_i,
    output logic [3:0]  alu_inst_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_ovf_i,
    input  logic        alu_br_i,
    output logic        busy_o,
    output logic        halt_o,
    output logic        err_o,
    output logic        carry_o,
    output logic [15:0] retired_o,
    input  logic [1:0]  dbg_sel_i,
    output logic [7:0]  dbg_rd_o
);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_e     state;
    inst_t      ir;
    logic [7:0] pc, rd1, rd2, wd;
    logic       exec, is_alu, is_br, illegal, we;

    alu_seq_rf u_rf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we      (we),
        .wa      (ir.ra),
        .wd      (wd),
        .ra1     (ir.ra),
        .ra2     (ir.rb),
        .dbg_sel (dbg_sel_i),
        .rd1     (rd1),
        .rd2     (rd2),
        .dbg_rd  (dbg_rd_o)
    );

    always_comb begin
        exec       = state == S_EXEC;
        is_alu     = ir.op <= OP_JMP;
        is_br      = ir.op inside {OP_BNE, OP_BEQ, OP_BLT};
        illegal    = ir.op inside {[4'hB:4'hE]};
        alu_inst_o = exec && is_alu ? ir.op : 4'h0;
        alu_a_o    = exec && is_alu ? (ir.op == OP_LHB ? ir.imm : rd1) : 8'h00;
        alu_b_o    = exec && is_alu ? rd2 : 8'h00;
        we         = exec && (ir.op <= OP_DEC || ir.op == OP_LHB);
        wd         = ir.op == OP_LHB ? ir.imm & 8'hF0 : alu_res_i;
    end

    assign imem_addr_o = pc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_req_o <= 1'b0;
            busy_o     <= 1'b0;
            halt_o     <= 1'b0;
            err_o      <= 1'b0;
            carry_o    <= 1'b0;
            retired_o  <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start_i) begin
                    state      <= S_FETCH;
                    pc         <= RESET_PC;
                    err_o      <= 1'b0;
                    carry_o    <= 1'b0;
                    imem_req_o <= 1'b1;
                    busy_o     <= 1'b1;
                    halt_o     <= 1'b0;
                end
                S_FETCH: begin
                    state      <= S_WAIT;
                    imem_req_o <= 1'b0;
                end
                S_WAIT: if (imem_rvalid_i) begin
                    state <= S_EXEC;
                    ir    <= imem_rdata_i;
                end
                S_EXEC: begin
                    retired_o <= retired_o + 16'd1;
                    if (ir.op == OP_ADD) carry_o <= alu_ovf_i;
                    if (illegal) err_o <= 1'b1;
                    if (ir.op == OP_HALT || (illegal && TRAP)) begin
                        state  <= S_HALT;
                        busy_o <= 1'b0;
                        halt_o <= 1'b1;
                    end else begin
                        state      <= S_FETCH;
                        imem_req_o <= 1'b1;
                        pc         <= ir.op == OP_JMP || (is_br && alu_br_i) ? ir.imm : pc + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random programs checked against an instruction-level model
module tb_alu_seq;

    logic        clk_i = 0, rst_ni = 0, start_i = 0;
    logic        imem_req_o, imem_rvalid_i = 0;
    logic [7:0]  imem_addr_o;
    logic [15:0] imem_rdata_i = '0;
    logic [3:0]  alu_inst_o;
    logic [7:0]  alu_a_o, alu_b_o, alu_res_i;
    logic        alu_ovf_i, alu_br_i;
    logic        busy_o, halt_o, err_o, carry_o;
    logic [15:0] retired_o;
    logic [1:0]  dbg_sel_i = 0;
    logic [7:0]  dbg_rd_o;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    alu_seq #(.RESET_PC(8'h00)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .alu_inst_o(alu_inst_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_res_i(alu_res_i), .alu_ovf_i(alu_ovf_i), .alu_br_i(alu_br_i),
        .busy_o(busy_o), .halt_o(halt_o), .err_o(err_o), .carry_o(carry_o),
        .retired_o(retired_o), .dbg_sel_i(dbg_sel_i), .dbg_rd_o(dbg_rd_o)
    );

    always #5 clk_i = ~clk_i;

    // external combinational ALU
    always_comb begin
        alu_res_i = '0;
        alu_ovf_i = 1'b0;
        alu_br_i  = 1'b0;
        case (alu_inst_o)
            4'h0: {alu_ovf_i, alu_res_i} = {1'b0, alu_a_o} + {1'b0, alu_b_o};
            4'h1: alu_res_i = alu_a_o - alu_b_o;
            4'h2: alu_res_i = alu_a_o << alu_b_o[2:0];
            4'h3: alu_res_i = alu_a_o >> alu_b_o[2:0];
            4'h4: alu_res_i = alu_a_o + 8'd1;
            4'h5: alu_res_i = alu_a_o - 8'd1;
            4'h6: alu_br_i  = alu_a_o != alu_b_o;
            4'h7: alu_br_i  = alu_a_o == alu_b_o;
            4'h8: alu_br_i  = alu_a_o < alu_b_o;
            4'h9: alu_res_i = alu_a_o & 8'hF0;
            default: ;
        endcase
    end

    logic [15:0] mem [256];
    logic [7:0]  fetch_q[$], exp_q[$];
    int          lat = 2, cnt = 0;
    logic [7:0]  addr_l;

    // instruction memory: answers each request after lat cycles, even across a reset
    initial forever begin
        @(posedge clk_i);
        #1;
        imem_rvalid_i = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem[addr_l];
            end
        end
        if (imem_req_o) begin
            addr_l = imem_addr_o;
            cnt    = lat;
            fetch_q.push_back(imem_addr_o);
        end
    end

    int          checks = 0, errors = 0;
    logic [7:0]  rf_m [4];
    logic [15:0] ret_m;
    logic        carry_m, err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input int s, output logic [7:0] v);
        dbg_sel_i = 2'(s);
        #1;
        v = dbg_rd_o;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        tick();
        tick();
        rst_ni = 1;
        for (int i = 0; i < 4; i++) rf_m[i] = 8'h00;
        ret_m = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    function automatic logic [15:0] ins(input int op, input int ra, input int rb, input int imm);
        return {4'(op), 2'(ra), 2'(rb), 8'(imm)};
    endfunction

    // instruction-level reference: executes the program in mem from address 0
    task automatic model_run();
        logic [7:0] pc, a, b, imm, nx;
        logic [8:0] sum;
        logic [15:0] w;
        bit halted;
        pc = 8'h00; carry_m = 0; err_m = 0; halted = 0;
        exp_q.delete();
        for (int n = 0; n < 1000 && !halted; n++) begin
            w = mem[pc];
            exp_q.push_back(pc);
            ret_m++;
            a = rf_m[w[11:10]];
            b = rf_m[w[9:8]];
            imm = w[7:0];
            nx = pc + 8'd1;
            case (w[15:12])
                4'h0: begin sum = a + b; rf_m[w[11:10]] = sum[7:0]; carry_m = sum[8]; end
                4'h1: rf_m[w[11:10]] = a - b;
                4'h2: rf_m[w[11:10]] = a << b[2:0];
                4'h3: rf_m[w[11:10]] = a >> b[2:0];
                4'h4: rf_m[w[11:10]] = a + 8'd1;
                4'h5: rf_m[w[11:10]] = a - 8'd1;
                4'h6: if (a != b) nx = imm;
                4'h7: if (a == b) nx = imm;
                4'h8: if (a < b) nx = imm;
                4'h9: rf_m[w[11:10]] = imm & 8'hF0;
                4'hA: nx = imm;
                4'hF: halted = 1;
                default: begin err_m = 1; if (TRAP) halted = 1; end
            endcase
            pc = nx;
        end
    endtask

    task automatic run_prog(input string tag, input int l, input bit spam);
        int n;
        logic [7:0] v;
        lat = l;
        fetch_q.delete();
        start_i = 1;
        tick();
        start_i = 0;
        n = 0;
        while (!halt_o && n < 3000) begin
            start_i = spam && busy_o;
            tick();
            n++;
        end
        start_i = 0;
        chk({tag, "_timeout"}, 32'(n < 3000), 1);
        model_run();
        chk({tag, "_halt"}, halt_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_err"}, err_o, err_m);
        chk({tag, "_carry"}, carry_o, carry_m);
        chk({tag, "_retired"}, retired_o, ret_m);
        for (int i = 0; i < 4; i++) begin
            rd(i, v);
            chk($sformatf("%s_rf%0d", tag, i), v, rf_m[i]);
        end
        chk({tag, "_nfetch"}, fetch_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fetch_q.size(); i++)
            chk($sformatf("%s_fetch%0d", tag, i), fetch_q[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] v;
        clear_mem();
        do_reset();
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_halt", halt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_carry", carry_o, 0);
        chk("rst_retired", retired_o, 0);
        chk("rst_alu", {alu_inst_o, alu_a_o, alu_b_o}, 0);
        rd(3, v);
        chk("rst_rf3", v, 0);

        mem[0] = ins(9, 0, 0, 8'h5A);
        run_prog("lhb", 2, 0);
        rd(0, v);
        chk("lhb_r0", v, 8'h50);
        chk("lhb_ret2", retired_o, 2);

        clear_mem();
        mem[0] = ins(9, 1, 0, 8'hF0);
        mem[1] = ins(9, 2, 0, 8'h20);
        mem[2] = ins(0, 1, 2, 0);
        mem[3] = ins(1, 1, 2, 0);
        run_prog("addsub", 1, 0);
        rd(1, v);
        chk("addsub_r1", v, 8'hF0);
        chk("addsub_carry", carry_o, 1);

        clear_mem();
        mem[8'h00] = ins(7, 0, 0, 8'h40);
        mem[8'h40] = ins(6, 0, 0, 8'h80);
        mem[8'h41] = ins(9, 3, 0, 8'h30);
        mem[8'h42] = ins(9, 2, 0, 8'h50);
        mem[8'h43] = ins(8, 3, 2, 8'h60);
        run_prog("branch", 3, 0);

        clear_mem();
        mem[0] = ins(9, 0, 0, 0);
        mem[1] = ins(9, 1, 0, 0);
        run_prog("pre", 1, 0);
        clear_mem();
        mem[8'h00] = ins(7, 0, 1, 8'h80);
        mem[8'h80] = ins(10, 0, 0, 8'hFF);
        mem[8'hFF] = ins(4, 0, 0, 0);
        run_prog("wrap", 2, 0);

        clear_mem();
        mem[0] = ins(12, 0, 0, 0);
        run_prog("illegal", 1, 0);
        chk("illegal_err", err_o, 1);

        clear_mem();
        mem[0] = ins(9, 2, 0, 8'h70);
        lat = 3;
        fetch_q.delete();
        start_i = 1;
        tick();
        start_i = 0;
        tick();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_busy", busy_o, 0);
        chk("abort_halt", halt_o, 0);
        chk("abort_req", imem_req_o, 0);
        chk("abort_addr", imem_addr_o, 8'h00);
        chk("abort_retired", retired_o, 0);
        chk("abort_nfetch", fetch_q.size(), 1);
        rd(2, v);
        chk("abort_rf2", v, 0);

        mem[1] = ins(4, 2, 0, 0);
        mem[2] = ins(0, 2, 2, 0);
        run_prog("spam", 2, 1);

        for (int p = 0; p < 8; p++) begin
            clear_mem();
            for (int i = 0; i < 20; i++) begin
                int op;
                op = $urandom_range(0, 15);
                mem[i] = ins(op, $urandom_range(0, 3), $urandom_range(0, 3),
                             (op inside {6, 7, 8, 10}) ? $urandom_range(i + 1, 20) : $urandom_range(0, 255));
            end
            run_prog($sformatf("rnd%0d", p), $urandom_range(1, 4), p[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
